cp0_exc_unit: RTL and testbench

// - Coprocessor-0 exception/interrupt unit; consumes the M-stage exception bundle (pc, delaySlot,

---
 rtl/cp0_pkg.sv | 60 ++++++
 rtl/cp0_exc_arbiter.sv | 38 +++
 rtl/cp0_exc_unit.sv | 123 ++++++++++++
 tb/tb_cp0_exc_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// CP0 exception unit shared definitions: register numbers, field positions,
// exception codes, writable masks and field-packing helpers.
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_ADDR_SR    = 5'd12;
  localparam logic [4:0] CP0_ADDR_CAUSE = 5'd13;
  localparam logic [4:0] CP0_ADDR_EPC   = 5'd14;
  localparam logic [4:0] CP0_ADDR_PRID  = 5'd15;

  // Exception entry address; the pipeline-register flush PC must use this value
  localparam logic [31:0] CP0_HANDLER_PC = 32'h0000_4180;

  // SR field positions
  localparam int SR_IE_BIT  = 0;
  localparam int SR_EXL_BIT = 1;
  localparam int SR_IM_LO   = 10;
  localparam int SR_IM_HI   = 15;

  // Cause field positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD_BIT = 31;

  // Exception codes
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Bits software may change through mtc0
  localparam logic [31:0] SR_WMASK  = 32'h0000_FC03;
  localparam logic [31:0] EPC_WMASK = 32'hFFFF_FFFF;

  // Assemble the architectural SR word from its fields
  function automatic logic [31:0] sr_pack(input logic [5:0] im, input logic exl,
                                          input logic ie);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[SR_IM_HI:SR_IM_LO] = im;
    w[SR_EXL_BIT]        = exl;
    w[SR_IE_BIT]         = ie;
    return w;
  endfunction

  // Assemble the architectural Cause word from its fields
  function automatic logic [31:0] cause_pack(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] exc);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[CAUSE_BD_BIT]              = bd;
    w[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
    w[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc;
    return w;
  endfunction

endpackage

// File: rtl/cp0_exc_arbiter.sv
// Combinational arbiter: decides whether an interrupt or an exception is taken
// this cycle and which ExcCode gets recorded. Interrupts beat exceptions.
module cp0_exc_arbiter
  import cp0_pkg::*;
(
  input  logic       i_en_rst_n,
  input  logic [5:0] i_hw_int,
  input  logic [5:0] i_im,
  input  logic       i_ie,
  input  logic       i_exl,
  input  logic [4:0] i_exc_code,
  output logic       o_int_req,
  output logic       o_exc_req,
  output logic       o_req,
  output logic [4:0] o_exc_code_sel
);

  // Request decode; everything is suppressed while held in reset or inside a handler
  always_comb begin
    o_int_req      = 1'b0;
    o_exc_req      = 1'b0;
    o_req          = 1'b0;
    o_exc_code_sel = EXC_INT;
    if (i_en_rst_n && !i_exl) begin
      o_int_req = (|(i_hw_int & i_im)) & i_ie;
      o_exc_req = (i_exc_code != 5'd0);
      o_req     = o_int_req | o_exc_req;
      if (o_int_req) begin
        o_exc_code_sel = EXC_INT;
      end else begin
        o_exc_code_sel = i_exc_code;
      end
    end else begin
      o_req = 1'b0;
    end
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception/interrupt unit. Holds SR/Cause/EPC/PRId, raises Req
// in the same cycle the M-stage bundle shows an exception or an enabled
// interrupt, serves mfc0/mtc0 and supplies the (bypassed) EPC for eret.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h2022_0C0C
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0Addr,
  input  logic [31:0] cp0WriteData,
  output logic [31:0] cp0ReadData,
  input  logic [31:0] pcIn,
  input  logic        delaySlotIn,
  input  logic [4:0]  excCodeIn,
  input  logic [5:0]  hwInt,
  input  logic        eretIn,
  output logic        Req,
  output logic [31:0] epcOut
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [4:0]  w_exc_code_sel;
  logic        w_wr_sr;
  logic        w_wr_epc;
  logic [31:0] w_sr_wdata;

  cp0_exc_arbiter u_arb (
    .i_en_rst_n     (reset),
    .i_hw_int       (hwInt),
    .i_im           (r_im),
    .i_ie           (r_ie),
    .i_exl          (r_exl),
    .i_exc_code     (excCodeIn),
    .o_int_req      (w_int_req),
    .o_exc_req      (w_exc_req),
    .o_req          (w_req),
    .o_exc_code_sel (w_exc_code_sel)
  );

  assign Req = w_req;

  // mtc0 write strobes; a write in a cycle that takes an exception is dropped
  always_comb begin
    w_wr_sr    = 1'b0;
    w_wr_epc   = 1'b0;
    w_sr_wdata = cp0WriteData & SR_WMASK;
    if (en && !w_req) begin
      w_wr_sr  = (cp0Addr == CP0_ADDR_SR);
      w_wr_epc = (cp0Addr == CP0_ADDR_EPC);
    end else begin
      w_wr_sr  = 1'b0;
      w_wr_epc = 1'b0;
    end
  end

  // CP0 state update: exception entry beats mtc0 and eret; IP samples hwInt every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im       <= 6'd0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= 6'd0;
      r_exc_code <= 5'd0;
      r_epc      <= 32'h0000_0000;
    end else begin
      r_ip <= hwInt;
      if (w_req) begin
        r_exl      <= 1'b1;
        r_exc_code <= w_exc_code_sel;
        r_bd       <= delaySlotIn;
        r_epc      <= delaySlotIn ? (pcIn - 32'd4) : pcIn;
      end else begin
        if (w_wr_sr) begin
          r_im  <= w_sr_wdata[SR_IM_HI:SR_IM_LO];
          r_exl <= w_sr_wdata[SR_EXL_BIT];
          r_ie  <= w_sr_wdata[SR_IE_BIT];
        end else if (eretIn) begin
          r_exl <= 1'b0;
        end
        if (w_wr_epc) begin
          r_epc <= cp0WriteData & EPC_WMASK;
        end
      end
    end
  end

  // mfc0 read mux; unmapped numbers read zero
  always_comb begin
    cp0ReadData = 32'h0000_0000;
    case (cp0Addr)
      CP0_ADDR_SR:    cp0ReadData = sr_pack(r_im, r_exl, r_ie);
      CP0_ADDR_CAUSE: cp0ReadData = cause_pack(r_bd, r_ip, r_exc_code);
      CP0_ADDR_EPC:   cp0ReadData = r_epc;
      CP0_ADDR_PRID:  cp0ReadData = PRID_VALUE;
      default:        cp0ReadData = 32'h0000_0000;
    endcase
  end

  // eret target with bypass of an mtc0 EPC in the same slot
  always_comb begin
    epcOut = r_epc;
    if (w_wr_epc) begin
      epcOut = cp0WriteData;
    end else begin
      epcOut = r_epc;
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit with hand-computed expected values.
module tb_cp0_exc_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  cp0Addr;
  logic [31:0] cp0WriteData;
  logic [31:0] cp0ReadData;
  logic [31:0] pcIn;
  logic        delaySlotIn;
  logic [4:0]  excCodeIn;
  logic [5:0]  hwInt;
  logic        eretIn;
  logic        Req;
  logic [31:0] epcOut;

  int n_checks = 0;
  int n_errors = 0;

  cp0_exc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .cp0Addr      (cp0Addr),
    .cp0WriteData (cp0WriteData),
    .cp0ReadData  (cp0ReadData),
    .pcIn         (pcIn),
    .delaySlotIn  (delaySlotIn),
    .excCodeIn    (excCodeIn),
    .hwInt        (hwInt),
    .eretIn       (eretIn),
    .Req          (Req),
    .epcOut       (epcOut)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_errors = n_errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // read a CP0 register combinationally and compare
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0Addr = a;
    #1;
    chk(tag, cp0ReadData, exp);
  endtask

  // advance through one posedge and land on the following negedge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; cp0Addr = 5'd0; cp0WriteData = 32'h0;
    pcIn = 32'h0; delaySlotIn = 1'b0; excCodeIn = 5'd0; hwInt = 6'd0; eretIn = 1'b0;
    @(negedge clk);
    tick();

    // reset state; Req forced low even with an exception pending
    excCodeIn = 5'd12;
    #1; chk("rst_req", {31'd0, Req}, 32'd0);
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);

    // overflow, not in delay slot
    excCodeIn = 5'd0; reset = 1'b1;
    tick();
    pcIn = 32'h3010; excCodeIn = 5'd12; delaySlotIn = 1'b0;
    #1; chk("ov_req", {31'd0, Req}, 32'd1);
    tick();
    excCodeIn = 5'd0;
    rd("ov_epc", 5'd14, 32'h0000_3010);
    rd("ov_cause", 5'd13, 32'h0000_0030);
    rd("ov_sr", 5'd12, 32'h0000_0002);
    chk("ov_epcout", epcOut, 32'h0000_3010);

    // inside handler: nothing taken
    excCodeIn = 5'd12; hwInt = 6'b000001;
    #1; chk("exl_mask_req", {31'd0, Req}, 32'd0);
    excCodeIn = 5'd0; hwInt = 6'd0; eretIn = 1'b1;
    tick();
    eretIn = 1'b0;
    rd("eret1_sr", 5'd12, 32'h0);

    // delay-slot exception
    pcIn = 32'h3024; delaySlotIn = 1'b1; excCodeIn = 5'd4;
    #1; chk("ds_req", {31'd0, Req}, 32'd1);
    tick();
    excCodeIn = 5'd0; delaySlotIn = 1'b0;
    rd("ds_epc", 5'd14, 32'h0000_3020);
    rd("ds_cause", 5'd13, 32'h8000_0010);
    eretIn = 1'b1;
    tick();
    eretIn = 1'b0;

    // enable IM[10] and IE
    en = 1'b1; cp0Addr = 5'd12; cp0WriteData = 32'h0000_0401;
    #1; chk("mtc0_sr_req", {31'd0, Req}, 32'd0);
    tick();
    en = 1'b0;
    rd("mtc0_sr", 5'd12, 32'h0000_0401);

    // interrupt beats simultaneous RI exception
    hwInt = 6'b000001; excCodeIn = 5'd10; pcIn = 32'h3100;
    #1; chk("int_req", {31'd0, Req}, 32'd1);
    tick();
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr", 5'd12, 32'h0000_0403);
    rd("int_epc", 5'd14, 32'h0000_3100);
    chk("int_masked_req", {31'd0, Req}, 32'd0);

    // eret with interrupt still pending: Req reasserts after EXL clears
    excCodeIn = 5'd0; eretIn = 1'b1;
    #1; chk("eret_req", {31'd0, Req}, 32'd0);
    tick();
    eretIn = 1'b0; pcIn = 32'h3200;
    #1; chk("reint_req", {31'd0, Req}, 32'd1);
    rd("reint_sr", 5'd12, 32'h0000_0401);
    tick();
    rd("reint_epc", 5'd14, 32'h0000_3200);

    // mtc0 EPC with eret in the same slot: bypass
    hwInt = 6'd0; en = 1'b1; cp0Addr = 5'd14; cp0WriteData = 32'h0000_3400; eretIn = 1'b1;
    #1; chk("byp_epcout", epcOut, 32'h0000_3400);
    chk("byp_req", {31'd0, Req}, 32'd0);
    tick();
    en = 1'b0; eretIn = 1'b0;
    rd("byp_epc", 5'd14, 32'h0000_3400);
    rd("byp_sr", 5'd12, 32'h0000_0401);

    // mtc0 SR colliding with an exception: write dropped, no EPC bypass
    en = 1'b1; cp0Addr = 5'd12; cp0WriteData = 32'h0000_0000; excCodeIn = 5'd5; pcIn = 32'h3300;
    #1; chk("cfl_req", {31'd0, Req}, 32'd1);
    cp0Addr = 5'd14; cp0WriteData = 32'hDEAD_BEEF;
    #1; chk("cfl_epcout", epcOut, 32'h0000_3400);
    cp0Addr = 5'd12; cp0WriteData = 32'h0000_0000;
    tick();
    en = 1'b0; excCodeIn = 5'd0;
    rd("cfl_sr", 5'd12, 32'h0000_0403);
    rd("cfl_cause", 5'd13, 32'h0000_0014);
    rd("cfl_epc", 5'd14, 32'h0000_3300);
    rd("prid", 5'd15, 32'h2022_0C0C);
    rd("unmapped", 5'd3, 32'h0);

    // mtc0 to Cause ignored
    en = 1'b1; cp0Addr = 5'd13; cp0WriteData = 32'hFFFF_FFFF;
    tick();
    en = 1'b0;
    rd("cause_ro", 5'd13, 32'h0000_0014);

    // reset asserted mid-handler clears immediately
    excCodeIn = 5'd12; reset = 1'b0;
    #1; chk("midrst_req", {31'd0, Req}, 32'd0);
    rd("midrst_sr", 5'd12, 32'h0);
    rd("midrst_epc", 5'd14, 32'h0);
    tick();
    reset = 1'b1; pcIn = 32'h3500;
    #1; chk("post_rst_req", {31'd0, Req}, 32'd1);
    tick();
    excCodeIn = 5'd0;
    rd("post_rst_epc", 5'd14, 32'h0000_3500);

    // delay-slot EPC wraps modulo 2^32
    eretIn = 1'b1;
    tick();
    eretIn = 1'b0; pcIn = 32'h0000_0000; delaySlotIn = 1'b1; excCodeIn = 5'd10;
    #1; chk("wrap_req", {31'd0, Req}, 32'd1);
    tick();
    excCodeIn = 5'd0; delaySlotIn = 1'b0;
    rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    rd("wrap_cause", 5'd13, 32'h8000_0028);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
